jk_seq_controller: RTL and testbench
====================================

Name: jk_seq_controller

Overview:
- Sequencer for a WIDTH-bit state register built from JK flip-flop cells.
- Each cycle it computes per-bit J/K excitation to hold, load, count up or count down toward a latched target.
- Uses a start/busy/done handshake.
- Sits between panel or top-level control logic and the counter/display datapath.

Parameters:
- WIDTH, 4, bits in the JK register bank and in load_val/limit/q.

Ports:
- clock  input  1  rising-edge system clock.
- reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
- start  input  1  request; sampled only in IDLE.
- mode  input  2  00 hold, 01 count up, 10 count down, 11 load; latched on an accepted start.
- load_val  input  WIDTH  value applied in load mode; latched on an accepted start.
- limit  input  WIDTH  target value for up/down; latched on an accepted start.
- stop  input  1  abort; honoured only in RUN.
- q  output  WIDTH  JK register contents.
- busy  output  1  high in LOAD and RUN.
- done  output  1  one-cycle pulse in DONE.

Behaviour:
- Reset (reset=0, asynchronous): q=0, state IDLE, busy=0, done=0, all latches cleared. Takes effect mid-operation in any state.
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE:
  - start=1 with mode 01/10 -> RUN.
  - start=1 with mode 11 -> LOAD.
  - mode 00 or start=0 -> stay in IDLE.
  - q holds (J=K=0 on every bit).
- Accept edge: latches mode, load_val and limit; q unchanged.
- LOAD: at the next edge q<=load_val_latched and the FSM goes to DONE.
- RUN, q!=limit_latched: q steps by 1 per edge, modulo 2^WIDTH (up: 15->0, down: 0->15 for WIDTH=4).
- RUN, q==limit_latched: the FSM goes to DONE at the next edge; q holds. If q already equals the target at accept, the first RUN edge goes to DONE with no step.
- RUN with stop=1: at the next edge -> IDLE, q holds, no done pulse. If stop=1 on the same edge where q==target, stop wins.
- DONE: done=1 for exactly one cycle, then IDLE.
- busy=1 iff state is LOAD or RUN.
- start while not in IDLE is ignored. Input changes after accept are ignored until the next accept.
- Excitation per bit i, with n = next value: J=~q[i]&n[i], K=q[i]&~n[i]. The bank never sees J=K=1 except under the optional feature.
- Arithmetic: WIDTH-bit increment/decrement, carry/borrow discarded.

Optional Feature:
- Macro: JK_AUTO_RELOAD_EN.
- When defined:
  - On reaching the target in RUN, done pulses for one cycle while the FSM stays in RUN.
  - At that edge q<=load_val_latched, and counting resumes from there at the following edges.
  - Only stop or reset leave RUN.
  - Reload bits use toggle excitation (J=K=1 where q differs from load_val_latched).
- When undefined: behaviour exactly as above (RUN -> DONE -> IDLE).

Decomposition:
- Shared package holds:
  - MODE_HOLD/MODE_UP/MODE_DOWN/MODE_LOAD 2-bit constants.
  - State encoding constants: IDLE=2'd0, LOAD=2'd1, RUN=2'd2, DONE=2'd3.
  - Default WIDTH.
- One sub-module, jk_cell:
  - Single JK flip-flop with asynchronous active-low clear, outputs q.
  - Instantiated WIDTH times via generate.
  - The controller's next-value/excitation logic and FSM stay in jk_seq_controller.

Test Plan:
- Reset: hold reset=0 for 2 cycles with random inputs, then release -> q=0, busy=0, done=0; no change until start.
- Count up: q=0, start with mode=01, limit=3 at edge E0 -> q=1,2,3 after E1,E2,E3; DONE after E4 (done=1, busy=0); IDLE after E5; q stays 3.
- Down with wrap: load 2 (mode 11, done pulses after E1), then mode=10, limit=14 -> q=1,0,15,14; done pulse; q stays 14.
- Stop mid-run: up from 0, limit=9, stop=1 when q=4 -> IDLE next edge, q=4, no done pulse; a following start with limit=6 counts 5,6.
- Reset mid-run: assert reset=0 between edges while q=5 in RUN -> q=0 and busy=0 immediately (before the next edge).
- Auto reload (macro defined): load_val=2, up, limit=4 -> q=1,2,3,4; done pulse; q=2,3,4; done pulse; repeats until stop.

Source files
------------

// File: rtl/jk_seq_controller_pkg.sv
// jk_seq_controller_pkg: mode codes, FSM state encoding and default width for the JK sequencer
package jk_seq_controller_pkg;
    localparam int DEFAULT_WIDTH = 4;
    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_UP   = 2'b01;
    localparam logic [1:0] MODE_DOWN = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] RUN  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;
endpackage

// File: rtl/jk_cell.sv
// jk_cell: single JK flip-flop with asynchronous active-low clear
module jk_cell (
    input  logic clock,
    input  logic reset,
    input  logic j,
    input  logic k,
    output logic q
);
    // 00 hold, 01 clear, 10 set, 11 toggle
    always_ff @(posedge clock or negedge reset)
        if (!reset) q <= 1'b0;
        else q <= (j & ~q) | (~k & q);
endmodule

// File: rtl/jk_seq_controller.sv
// jk_seq_controller: start/busy/done sequencer driving a JK register bank to hold, load or count toward a target
// Optional feature macro JK_AUTO_RELOAD_EN: on reaching the target, pulse done, reload load_val and keep counting.
module jk_seq_controller
    import jk_seq_controller_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] limit,
    input  logic             stop,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done
);
    logic [1:0]       state, state_n, mode_l;
    logic [WIDTH-1:0] load_l, limit_l, step, n, j, k;
    logic             accept, at_limit, reload;

    assign accept   = state == IDLE && start && mode != MODE_HOLD;
    assign at_limit = q == limit_l;
    assign busy     = state == LOAD || state == RUN;

`ifdef JK_AUTO_RELOAD_EN
    logic done_r;
    assign reload = state == RUN && !stop && at_limit;
    assign done   = state == DONE || done_r;
    // done follows the reload edge by one cycle, matching DONE-state timing
    always_ff @(posedge clock or negedge reset)
        if (!reset) done_r <= 1'b0;
        else done_r <= reload;
`else
    assign reload = 1'b0;
    assign done   = state == DONE;
`endif

    // next register value and per-bit excitation; reload toggles only differing bits
    always_comb begin
        step = mode_l == MODE_UP ? q + 1'b1 : q - 1'b1;
        n    = state == LOAD ? load_l : (state == RUN && !stop && !at_limit) ? step : q;
        j    = reload ? q ^ load_l : ~q & n;
        k    = reload ? q ^ load_l : q & ~n;
    end

    // FSM transitions; stop outranks reaching the target
    always_comb begin
        state_n = state;
        case (state)
            IDLE: state_n = accept ? (mode == MODE_LOAD ? LOAD : RUN) : IDLE;
            LOAD: state_n = DONE;
`ifdef JK_AUTO_RELOAD_EN
            RUN:  state_n = stop ? IDLE : RUN;
`else
            RUN:  state_n = stop ? IDLE : at_limit ? DONE : RUN;
`endif
            default: state_n = IDLE;
        endcase
    end

    // state register and operand latches captured on an accepted start
    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            state   <= IDLE;
            mode_l  <= MODE_HOLD;
            load_l  <= '0;
            limit_l <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                mode_l  <= mode;
                load_l  <= load_val;
                limit_l <= limit;
            end
        end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        jk_cell u_cell (
            .clock(clock),
            .reset(reset),
            .j    (j[i]),
            .k    (k[i]),
            .q    (q[i])
        );
    end
endmodule

// File: tb/tb_jk_seq_controller.sv
// tb_jk_seq_controller: directed scoreboard bench for jk_seq_controller (WIDTH=4)
module tb_jk_seq_controller;
    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [3:0] load_val = '0;
    logic [3:0] limit = '0;
    logic       stop = 1'b0;
    logic [3:0] q;
    logic       busy, done;

    typedef struct {
        string      tag;
        logic [3:0] q;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t sb[$];
    int   compared = 0;
    int   mismatched = 0;

    jk_seq_controller #(.WIDTH(4)) dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .mode    (mode),
        .load_val(load_val),
        .limit   (limit),
        .stop    (stop),
        .q       (q),
        .busy    (busy),
        .done    (done)
    );

    always #5 clock = ~clock;

    task automatic push(input string tag, input logic [3:0] eq, input logic eb, input logic ed);
        exp_t e;
        e.tag = tag;
        e.q = eq;
        e.busy = eb;
        e.done = ed;
        sb.push_back(e);
    endtask

    task automatic check();
        exp_t e;
        e = sb.pop_front();
        compared++;
        assert ({q, busy, done} === {e.q, e.busy, e.done})
        else begin
            mismatched++;
            $error("FAIL %s: got q=%0d busy=%b done=%b, expected q=%0d busy=%b done=%b",
                   e.tag, q, busy, done, e.q, e.busy, e.done);
        end
    endtask

    task automatic cyc(input string tag, input logic [3:0] eq, input logic eb, input logic ed);
        push(tag, eq, eb, ed);
        @(posedge clock);
        #1;
        check();
    endtask

    task automatic now(input string tag, input logic [3:0] eq, input logic eb, input logic ed);
        push(tag, eq, eb, ed);
        check();
    endtask

    task automatic go(input logic [1:0] m, input logic [3:0] lv, input logic [3:0] lim);
        mode = m;
        load_val = lv;
        limit = lim;
        start = 1'b1;
    endtask

    initial begin
        for (int c = 0; c < 2; c++) begin
            start = 1'($urandom);
            mode = 2'($urandom);
            load_val = 4'($urandom);
            limit = 4'($urandom);
            stop = 1'($urandom);
            @(posedge clock);
            #1;
            now("in_reset", 4'd0, 1'b0, 1'b0);
        end
        start = 1'b0;
        stop = 1'b0;
        reset = 1'b1;
        now("after_reset", 4'd0, 1'b0, 1'b0);
        cyc("idle0", 4'd0, 1'b0, 1'b0);
        go(2'b00, 4'd9, 4'd9);
        cyc("hold_mode_ignored", 4'd0, 1'b0, 1'b0);

`ifdef JK_AUTO_RELOAD_EN
        go(2'b01, 4'd2, 4'd4);
        cyc("ar_accept", 4'd0, 1'b1, 1'b0);
        start = 1'b0;
        cyc("ar_q1", 4'd1, 1'b1, 1'b0);
        cyc("ar_q2", 4'd2, 1'b1, 1'b0);
        cyc("ar_q3", 4'd3, 1'b1, 1'b0);
        cyc("ar_q4", 4'd4, 1'b1, 1'b0);
        cyc("ar_reload1", 4'd2, 1'b1, 1'b1);
        cyc("ar_q3b", 4'd3, 1'b1, 1'b0);
        cyc("ar_q4b", 4'd4, 1'b1, 1'b0);
        cyc("ar_reload2", 4'd2, 1'b1, 1'b1);
        cyc("ar_q3c", 4'd3, 1'b1, 1'b0);
        stop = 1'b1;
        cyc("ar_stop", 4'd3, 1'b0, 1'b0);
        stop = 1'b0;
        cyc("ar_idle", 4'd3, 1'b0, 1'b0);
        go(2'b11, 4'd1, 4'd0);
        cyc("ar_load_acc", 4'd3, 1'b1, 1'b0);
        start = 1'b0;
        cyc("ar_load_done", 4'd1, 1'b0, 1'b1);
        cyc("ar_load_idle", 4'd1, 1'b0, 1'b0);
`else
        go(2'b01, 4'd0, 4'd3);
        cyc("up_accept", 4'd0, 1'b1, 1'b0);
        start = 1'b0;
        limit = 4'd7;
        cyc("up_q1", 4'd1, 1'b1, 1'b0);
        cyc("up_q2", 4'd2, 1'b1, 1'b0);
        cyc("up_q3", 4'd3, 1'b1, 1'b0);
        cyc("up_done", 4'd3, 1'b0, 1'b1);
        cyc("up_idle", 4'd3, 1'b0, 1'b0);

        go(2'b11, 4'd2, 4'd0);
        cyc("load_accept", 4'd3, 1'b1, 1'b0);
        start = 1'b0;
        cyc("load_done", 4'd2, 1'b0, 1'b1);
        cyc("load_idle", 4'd2, 1'b0, 1'b0);
        go(2'b10, 4'd0, 4'd14);
        cyc("dn_accept", 4'd2, 1'b1, 1'b0);
        mode = 2'b01;
        limit = 4'd0;
        cyc("dn_q1", 4'd1, 1'b1, 1'b0);
        cyc("dn_q0", 4'd0, 1'b1, 1'b0);
        cyc("dn_wrap15", 4'd15, 1'b1, 1'b0);
        cyc("dn_q14", 4'd14, 1'b1, 1'b0);
        cyc("dn_done", 4'd14, 1'b0, 1'b1);
        start = 1'b0;
        cyc("dn_idle", 4'd14, 1'b0, 1'b0);

        go(2'b11, 4'd0, 4'd0);
        cyc("ld0_accept", 4'd14, 1'b1, 1'b0);
        start = 1'b0;
        cyc("ld0_done", 4'd0, 1'b0, 1'b1);
        cyc("ld0_idle", 4'd0, 1'b0, 1'b0);
        go(2'b01, 4'd0, 4'd9);
        cyc("st_accept", 4'd0, 1'b1, 1'b0);
        start = 1'b0;
        for (int v = 1; v <= 4; v++) cyc("st_count", 4'(v), 1'b1, 1'b0);
        stop = 1'b1;
        cyc("st_abort", 4'd4, 1'b0, 1'b0);
        stop = 1'b0;
        cyc("st_no_done", 4'd4, 1'b0, 1'b0);
        go(2'b01, 4'd0, 4'd6);
        cyc("st2_accept", 4'd4, 1'b1, 1'b0);
        start = 1'b0;
        cyc("st2_q5", 4'd5, 1'b1, 1'b0);
        cyc("st2_q6", 4'd6, 1'b1, 1'b0);
        cyc("st2_done", 4'd6, 1'b0, 1'b1);
        cyc("st2_idle", 4'd6, 1'b0, 1'b0);

        go(2'b01, 4'd0, 4'd6);
        cyc("eq_stop_accept", 4'd6, 1'b1, 1'b0);
        start = 1'b0;
        stop = 1'b1;
        cyc("eq_stop_wins", 4'd6, 1'b0, 1'b0);
        stop = 1'b0;
        cyc("eq_stop_idle", 4'd6, 1'b0, 1'b0);
        go(2'b10, 4'd0, 4'd6);
        cyc("eq_accept", 4'd6, 1'b1, 1'b0);
        start = 1'b0;
        cyc("eq_done_nostep", 4'd6, 1'b0, 1'b1);
        cyc("eq_idle", 4'd6, 1'b0, 1'b0);

        go(2'b11, 4'd15, 4'd0);
        cyc("ld15_accept", 4'd6, 1'b1, 1'b0);
        start = 1'b0;
        cyc("ld15_done", 4'd15, 1'b0, 1'b1);
        cyc("ld15_idle", 4'd15, 1'b0, 1'b0);
        go(2'b01, 4'd0, 4'd1);
        cyc("upw_accept", 4'd15, 1'b1, 1'b0);
        start = 1'b0;
        cyc("upw_wrap0", 4'd0, 1'b1, 1'b0);
        cyc("upw_q1", 4'd1, 1'b1, 1'b0);
        cyc("upw_done", 4'd1, 1'b0, 1'b1);
        cyc("upw_idle", 4'd1, 1'b0, 1'b0);
`endif

        go(2'b01, 4'd1, 4'd12);
        cyc("rst_accept", q, 1'b1, 1'b0);
        start = 1'b0;
        for (int s = 0; s < 20 && q != 4'd5; s++) begin
            @(posedge clock);
            #1;
        end
        now("rst_reach5", 4'd5, 1'b1, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        now("rst_async", 4'd0, 1'b0, 1'b0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        cyc("rst_idle", 4'd0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
